// File: rtl/scm_march_bist_ctrl_if.sv
// SCM test-port bundle between the march BIST engine (master) and the SCM test wrapper (slave).
interface scm_march_bist_ctrl_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BYTE   = DATA_WIDTH/8
);
  logic                  BIST;
  logic                  CSN_T;
  logic                  WEN_T;
  logic [ADDR_WIDTH-1:0] A_T;
  logic [DATA_WIDTH-1:0] D_T;
  logic [NUM_BYTE-1:0]   BE_T;
  logic [DATA_WIDTH-1:0] Q_T;

  modport master (output BIST, CSN_T, WEN_T, A_T, D_T, BE_T, input Q_T);
  modport slave  (input BIST, CSN_T, WEN_T, A_T, D_T, BE_T, output Q_T);
endinterface

// File: rtl/scm_march_bist_ctrl.sv
// March C- BIST engine for the SCM test wrapper: one op per cycle, pipelined read compare.
// Optional SCM_BIST_CHECKERBOARD_EN repeats the march with a 0x55.. background.

// Per-byte-lane comparator; the engine instantiates one per byte enable.
module scm_march_bist_lane (
  input  logic [7:0] q_byte,
  input  logic [7:0] exp_byte,
  output logic       mis
);
  assign mis = (q_byte != exp_byte);
endmodule

module scm_march_bist_ctrl #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_BYTE     = DATA_WIDTH/8,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fail_o,
  output logic [ADDR_WIDTH-1:0] fail_addr_o,
  output logic [7:0]            err_cnt_o,
  scm_march_bist_ctrl_if.master scm
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_M0    = 4'd1;
  localparam logic [3:0] S_M1    = 4'd2;
  localparam logic [3:0] S_M2    = 4'd3;
  localparam logic [3:0] S_M3    = 4'd4;
  localparam logic [3:0] S_M4    = 4'd5;
  localparam logic [3:0] S_M5    = 4'd6;
  localparam logic [3:0] S_DRAIN = 4'd7;
  localparam logic [3:0] S_DONE  = 4'd8;

  localparam int DCW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [DCW-1:0]        DRAIN_END = DCW'(READ_LATENCY-1);

  logic [3:0]            state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic                  phase, phase_nxt;   // 0 = read half, 1 = write half of a two-op element
  logic [DCW-1:0]        drain_cnt, drain_nxt;
  logic [DATA_WIDTH-1:0] d_last;
  logic [DATA_WIDTH-1:0] bg, wdata, rdata_exp;
  logic                  in_march, two_op, is_wr, is_rd, wr_inv, rd_inv;
  logic                  accept, mismatch;

  // ---------------------------------------------------------------------------
  // Background pattern
  // ---------------------------------------------------------------------------
`ifdef SCM_BIST_CHECKERBOARD_EN
  localparam logic [DATA_WIDTH-1:0] CB_PAT = {(DATA_WIDTH/2){2'b01}};
  logic pass, pass_nxt;
  assign bg = pass ? CB_PAT : '0;
`else
  assign bg = '0;
`endif

  // ---------------------------------------------------------------------------
  // Op decode for the element currently on the bus
  // ---------------------------------------------------------------------------
  assign in_march  = (state >= S_M0) && (state <= S_M5);
  assign two_op    = (state >= S_M1) && (state <= S_M4);
  assign is_wr     = (state == S_M0) || (two_op && phase);
  assign is_rd     = (state == S_M5) || (two_op && !phase);
  assign wr_inv    = (state == S_M1) || (state == S_M3);
  assign rd_inv    = (state == S_M2) || (state == S_M4);
  assign wdata     = wr_inv ? ~bg : bg;
  assign rdata_exp = rd_inv ? ~bg : bg;
  assign accept    = start_i && ((state == S_IDLE) || (state == S_DONE));

  // ---------------------------------------------------------------------------
  // March sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    phase_nxt = phase;
    drain_nxt = drain_cnt;
`ifdef SCM_BIST_CHECKERBOARD_EN
    pass_nxt  = pass;
`endif
    case (state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_nxt = S_M0;
          addr_nxt  = '0;
          phase_nxt = 1'b0;
`ifdef SCM_BIST_CHECKERBOARD_EN
          pass_nxt  = 1'b0;
`endif
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_M0: begin
        if (addr == ADDR_LAST) begin
          state_nxt = S_M1;
          addr_nxt  = '0;
        end else begin
          addr_nxt = addr + ADDR_ONE;
        end
      end
      S_M1, S_M2: begin
        if (!phase) begin
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (addr == ADDR_LAST) begin
            // M2 hands over to the first down element, which starts at the top
            state_nxt = (state == S_M1) ? S_M2 : S_M3;
            addr_nxt  = (state == S_M1) ? '0 : ADDR_LAST;
          end else begin
            addr_nxt = addr + ADDR_ONE;
          end
        end
      end
      S_M3, S_M4: begin
        if (!phase) begin
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (addr == '0) begin
            state_nxt = (state == S_M3) ? S_M4 : S_M5;
            addr_nxt  = (state == S_M3) ? ADDR_LAST : '0;
          end else begin
            addr_nxt = addr - ADDR_ONE;
          end
        end
      end
      S_M5: begin
        if (addr == ADDR_LAST) begin
`ifdef SCM_BIST_CHECKERBOARD_EN
          if (!pass) begin
            state_nxt = S_M0;
            addr_nxt  = '0;
            pass_nxt  = 1'b1;
          end else begin
            state_nxt = S_DRAIN;
            drain_nxt = '0;
          end
`else
          state_nxt = S_DRAIN;
          drain_nxt = '0;
`endif
        end else begin
          addr_nxt = addr + ADDR_ONE;
        end
      end
      S_DRAIN: begin
        // Hold until the last read has left the compare pipeline
        if (drain_cnt == DRAIN_END) state_nxt = S_DONE;
        else                        drain_nxt = drain_cnt + DCW'(1);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      phase     <= 1'b0;
      drain_cnt <= '0;
      d_last    <= '0;
`ifdef SCM_BIST_CHECKERBOARD_EN
      pass      <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      phase     <= phase_nxt;
      drain_cnt <= drain_nxt;
      if (is_wr) d_last <= wdata;
`ifdef SCM_BIST_CHECKERBOARD_EN
      pass      <= pass_nxt;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // SCM test port and status
  // ---------------------------------------------------------------------------
  assign busy_o    = (state != S_IDLE) && (state != S_DONE);
  assign done_o    = (state == S_DONE);
  assign scm.BIST  = busy_o;
  assign scm.CSN_T = ~in_march;
  assign scm.WEN_T = ~is_wr;
  assign scm.A_T   = addr;
  assign scm.D_T   = is_wr ? wdata : d_last;
  assign scm.BE_T  = {NUM_BYTE{busy_o}};

  // ---------------------------------------------------------------------------
  // Read compare pipeline: stage 0 is the read on the bus, stage RL meets Q_T
  // ---------------------------------------------------------------------------
  logic [READ_LATENCY:1]                 vld_pipe;
  logic [READ_LATENCY:1][DATA_WIDTH-1:0] exp_pipe;
  logic [READ_LATENCY:1][ADDR_WIDTH-1:0] adr_pipe;
  logic [DATA_WIDTH-1:0]                 exp_out;
  logic [NUM_BYTE-1:0]                   lane_mis;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      exp_pipe <= '0;
      adr_pipe <= '0;
    end else begin
      vld_pipe[1] <= is_rd;
      exp_pipe[1] <= rdata_exp;
      adr_pipe[1] <= addr;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        exp_pipe[i] <= exp_pipe[i-1];
        adr_pipe[i] <= adr_pipe[i-1];
      end
    end
  end

  assign exp_out = exp_pipe[READ_LATENCY];

  for (genvar g = 0; g < NUM_BYTE; g++) begin : g_lane
    scm_march_bist_lane u_lane (
      .q_byte   (scm.Q_T[g*8 +: 8]),
      .exp_byte (exp_out[g*8 +: 8]),
      .mis      (lane_mis[g])
    );
  end

  assign mismatch = vld_pipe[READ_LATENCY] && (|lane_mis);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      err_cnt_o   <= '0;
    end else if (accept) begin
      fail_o      <= 1'b0;
      fail_addr_o <= '0;
      err_cnt_o   <= '0;
    end else if (mismatch) begin
      if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      if (!fail_o) begin
        fail_o      <= 1'b1;
        fail_addr_o <= adr_pipe[READ_LATENCY];
      end
    end
  end

endmodule
